// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and FSM state encoding.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier. The first partial product is folded into the
// start cycle, so busy drops after CYCLES clock edges (including the start edge)
// and product holds the full 2*WIDTH-bit result until the next start.
module seq_alu_mul #(
    parameter int WIDTH  = 4,
    parameter int CYCLES = WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    // Load operands with the first partial product, then add one shifted partial product per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
            mplier_q <= b >> 1;
            acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
            cnt_q    <= CW'(CYCLES - 1);
        end else if (cnt_q != {CW{1'b0}}) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            cnt_q    <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            mcand_q  <= mcand_q;
            mplier_q <= mplier_q;
            acc_q    <= acc_q;
            cnt_q    <= cnt_q;
        end
    end

    assign busy    = (cnt_q != {CW{1'b0}});
    assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with IDLE/EXEC/MUL/DONE control FSM and registered results.
// Optional feature macro: SEQ_ALU_MUL_EN enables the iterative multiplier for
// opcode 110; without it that opcode reports err=1 and leaves the result alone.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] rezult,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2 || WIDTH > 16 || MUL_CYCLES != WIDTH) begin : g_param_check
        $error("seq_alu: WIDTH must be 2..16 and MUL_CYCLES must equal WIDTH");
    end

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rez_q;
    logic             carry_q, zero_q, err_q, busy_q, done_q;
    logic [WIDTH-1:0] res_s;
    logic             cy_s, err_s;
    logic [WIDTH:0]   sum_s, diff_s;
    logic             accept_s;

    assign accept_s = (state_q == ST_IDLE) && enable;

`ifdef SEQ_ALU_MUL_EN
    logic               mul_start_s, mul_busy_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    assign mul_start_s = accept_s && (operation == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH), .CYCLES(MUL_CYCLES)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (operand_a),
        .b       (operand_b),
        .busy    (mul_busy_s),
        .product (mul_prod_s)
    );
`endif

    // Next-state logic; enable is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
`ifdef SEQ_ALU_MUL_EN
                    if (operation == OP_MUL) state_d = ST_MUL;
                    else                     state_d = ST_EXEC;
`else
                    state_d = ST_EXEC;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_DONE;
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: begin
                if (!mul_busy_s) state_d = ST_DONE;
                else             state_d = ST_MUL;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result datapath from the latched operands; an unsupported op keeps the old result.
    always_comb begin
        sum_s  = {1'b0, a_q} + {1'b0, b_q};
        diff_s = {1'b0, a_q} - {1'b0, b_q};
        res_s  = rez_q;
        cy_s   = 1'b0;
        err_s  = 1'b0;
        case (op_q)
            OP_ADD: begin res_s = sum_s[WIDTH-1:0];  cy_s = sum_s[WIDTH];  end
            OP_SUB: begin res_s = diff_s[WIDTH-1:0]; cy_s = diff_s[WIDTH]; end
            OP_AND: res_s = a_q & b_q;
            OP_OR:  res_s = a_q | b_q;
            OP_XOR: res_s = a_q ^ b_q;
            OP_SHL: begin
                if ({1'b0, b_q} >= (WIDTH+1)'(WIDTH)) res_s = {WIDTH{1'b0}};
                else                                  res_s = a_q << b_q;
            end
            OP_CMP: res_s = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                res_s = mul_prod_s[WIDTH-1:0];
                cy_s  = |mul_prod_s[2*WIDTH-1:WIDTH];
`else
                res_s = rez_q;
                cy_s  = carry_q;
                err_s = 1'b1;
`endif
            end
            default: begin res_s = rez_q; cy_s = carry_q; err_s = 1'b1; end
        endcase
    end

    // State, operand latch and busy register; operands only load on an accepted enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            if (accept_s) begin
                op_q <= op_e'(operation);
                a_q  <= operand_a;
                b_q  <= operand_b;
            end else begin
                op_q <= op_q;
                a_q  <= a_q;
                b_q  <= b_q;
            end
        end
    end

    // Output registers update only when leaving DONE, producing the one-cycle done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rez_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == ST_DONE) begin
            rez_q   <= res_s;
            carry_q <= cy_s;
            zero_q  <= (res_s == {WIDTH{1'b0}});
            err_q   <= err_s;
            done_q  <= 1'b1;
        end else begin
            done_q  <= 1'b0;
        end
    end

    assign rezult = rez_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=4). Expected results are queued at issue
// time and checked by an independent monitor whenever done pulses.
module tb_seq_alu;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [2:0] operation;
    logic [3:0] operand_a, operand_b;
    logic [3:0] rezult;
    logic       carry, zero, err, busy, done;

    typedef struct {
        logic [3:0] rez;
        logic       c;
        logic       z;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

`ifdef SEQ_ALU_MUL_EN
    localparam int MUL_LAT = 5;
`else
    localparam int MUL_LAT = 2;
`endif

    seq_alu #(.WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .operation (operation),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rezult    (rezult),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pop and compare one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rezult", {28'd0, rezult}, {28'd0, e.rez});
                    chk("carry", {31'd0, carry}, {31'd0, e.c});
                    chk("zero", {31'd0, zero}, {31'd0, e.z});
                    chk("err", {31'd0, err}, {31'd0, e.e});
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one operation, push its expectation, fire a stray enable while busy, wait for idle.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic ec, input logic ez, input logic ee,
                         input int lat);
        exp_t e;
        int   n;
        @(negedge clock);
        operation = op;
        operand_a = a;
        operand_b = b;
        enable    = 1'b1;
        e.rez = er; e.c = ec; e.z = ez; e.e = ee; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clock);
        chk("busy_after_enable", {31'd0, busy}, 32'd1);
        operation = 3'b000;
        operand_a = 4'd1;
        operand_b = 4'd1;
        @(negedge clock);
        enable = 1'b0;
        n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            chk("idle_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; enable = 1'b0; operation = 3'b000; operand_a = 4'd0; operand_b = 4'd0;
        repeat (2) @(negedge clock);
        chk("rst_rezult", {28'd0, rezult}, 32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        //     op      a      b      rez    c     z     err   lat
        issue(3'b000, 4'd15, 4'd1,  4'd0,  1'b1, 1'b1, 1'b0, 2);
        issue(3'b001, 4'd9,  4'd6,  4'd3,  1'b0, 1'b0, 1'b0, 2);
        issue(3'b001, 4'd6,  4'd9,  4'd13, 1'b1, 1'b0, 1'b0, 2);
        repeat (3) @(negedge clock);
        chk("hold_rezult", {28'd0, rezult}, 32'd13);
        chk("hold_carry", {31'd0, carry}, 32'd1);
        chk("hold_done_low", {31'd0, done}, 32'd0);
        issue(3'b010, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0, 1'b0, 2);
        issue(3'b011, 4'd12, 4'd3,  4'd15, 1'b0, 1'b0, 1'b0, 2);
        issue(3'b100, 4'd15, 4'd5,  4'd10, 1'b0, 1'b0, 1'b0, 2);
        issue(3'b101, 4'd3,  4'd5,  4'd0,  1'b0, 1'b1, 1'b0, 2);
        issue(3'b101, 4'd3,  4'd2,  4'd12, 1'b0, 1'b0, 1'b0, 2);
        issue(3'b101, 4'd1,  4'd3,  4'd8,  1'b0, 1'b0, 1'b0, 2);
        issue(3'b101, 4'd1,  4'd4,  4'd0,  1'b0, 1'b1, 1'b0, 2);
        issue(3'b111, 4'd2,  4'd9,  4'd1,  1'b0, 1'b0, 1'b0, 2);
        issue(3'b111, 4'd9,  4'd2,  4'd0,  1'b0, 1'b1, 1'b0, 2);
        issue(3'b111, 4'd5,  4'd5,  4'd0,  1'b0, 1'b1, 1'b0, 2);
        issue(3'b000, 4'd2,  4'd3,  4'd5,  1'b0, 1'b0, 1'b0, 2);
`ifdef SEQ_ALU_MUL_EN
        issue(3'b110, 4'd7,  4'd3,  4'd5,  1'b1, 1'b0, 1'b0, MUL_LAT);
        issue(3'b110, 4'd2,  4'd2,  4'd4,  1'b0, 1'b0, 1'b0, MUL_LAT);
        issue(3'b110, 4'd15, 4'd15, 4'd1,  1'b1, 1'b0, 1'b0, MUL_LAT);
        issue(3'b110, 4'd4,  4'd4,  4'd0,  1'b1, 1'b1, 1'b0, MUL_LAT);
        e.rez = 4'd0; e.c = 1'b1; e.z = 1'b1; e.e = 1'b0;
`else
        issue(3'b110, 4'd7,  4'd3,  4'd5,  1'b0, 1'b0, 1'b1, MUL_LAT);
        issue(3'b110, 4'd2,  4'd2,  4'd5,  1'b0, 1'b0, 1'b1, MUL_LAT);
        issue(3'b000, 4'd2,  4'd3,  4'd5,  1'b0, 1'b0, 1'b0, 2);
        issue(3'b110, 4'd15, 4'd15, 4'd5,  1'b0, 1'b0, 1'b1, MUL_LAT);
        e.rez = 4'd5; e.c = 1'b0; e.z = 1'b0; e.e = 1'b1;
`endif

        // Reset during the third multiplier cycle, then the first enable must be accepted.
        @(negedge clock);
        operation = 3'b110; operand_a = 4'd7; operand_b = 4'd3; enable = 1'b1;
`ifdef SEQ_ALU_MUL_EN
        e.rez = 4'd5; e.c = 1'b1; e.z = 1'b0; e.e = 1'b0;
`endif
        e.cyc = cyc + 1 + MUL_LAT;
        sb.push_back(e);
        @(negedge clock);
        enable = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rezult", {28'd0, rezult}, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        chk("midrst_carry", {31'd0, carry}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        issue(3'b000, 4'd2,  4'd3,  4'd5,  1'b0, 1'b0, 1'b0, 2);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 Parameter MUL_CYCLES, default WIDTH, number of multiplier iteration cycles; fixed equal to WIDTH.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  start strobe, sampled on the rising clock edge.
REQ-007 operation  in  3  operation select, sampled with enable.
REQ-008 operand_a  in  WIDTH  first operand, unsigned.
REQ-009 operand_b  in  WIDTH  second operand, unsigned.
REQ-010 rezult  out  WIDTH  registered result.
REQ-011 carry  out  1  carry, borrow or overflow flag.
REQ-012 zero  out  1  high when rezult equals 0.
REQ-013 err  out  1  illegal or unsupported operation flag.
REQ-014 busy  out  1  high while an operation is in flight.
REQ-015 done  out  1  one-cycle pulse when rezult and the flags update.

Function
REQ-016 Opcodes are: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 CMP.
REQ-017 FSM states SHALL be IDLE, EXEC, MUL, DONE.
  - IDLE: enable goes to EXEC (MUL if op=110); operands and op latched.
  - EXEC goes to DONE.
  - MUL goes to DONE after MUL_CYCLES.
  - DONE goes to IDLE.
REQ-018 A single-cycle op SHALL raise done exactly 2 cycles after the enable edge; a MUL SHALL raise done MUL_CYCLES+1 cycles after that edge.
REQ-019 busy SHALL be high in EXEC, MUL and DONE, and low in IDLE.
REQ-020 enable while busy SHALL be ignored; operands are not relatched.
REQ-021 ADD: rezult=(a+b) mod 2^WIDTH, carry=carry-out.
REQ-022 SUB: rezult=(a-b) mod 2^WIDTH, carry=borrow (a<b).
REQ-023 AND/OR/XOR: bitwise, carry=0.
REQ-024 SHL: rezult=a<<b, or 0 when b>=WIDTH; carry=0.
REQ-025 MUL: shift-add, rezult=low WIDTH bits of a*b; carry=1 when any high WIDTH bits are nonzero.
REQ-026 CMP: rezult=1 if a<b else 0; carry=0.
REQ-027 rezult, carry, zero and err SHALL hold their values between done pulses.
REQ-028 err=0 for all supported ops.

Reset
REQ-029 Asserting reset at any time, including mid-MUL, SHALL force state IDLE and rezult=0, carry=0, zero=1, err=0, busy=0, done=0.
REQ-030 The first enable after reset deassertion SHALL be accepted normally.

Configuration
REQ-031 Macro SEQ_ALU_MUL_EN defined: MUL is implemented per REQ-025.
REQ-032 Macro SEQ_ALU_MUL_EN undefined: op 110 takes the EXEC path, done pulses per single-cycle latency, err=1, and rezult/carry/zero keep their previous values; no multiplier logic is synthesised.

Structure
REQ-033 Package seq_alu_pkg SHALL hold the opcode and FSM state typedefs/constants.
REQ-034 Sub-module seq_alu_mul SHALL implement the iterative shift-add multiplier (start, busy, product), instantiated only under SEQ_ALU_MUL_EN.

Verification
REQ-035 WIDTH=4, ADD a=15 b=1 -> rezult=0, carry=1, zero=1, done 2 cycles after enable.
REQ-036 SUB a=9 b=6 -> rezult=3, carry=0; then SUB a=6 b=9 -> rezult=13, carry=1.
REQ-037 MUL a=7 b=3 with macro -> rezult=5, carry=1, done 5 cycles after enable; a second enable at cycle 2 is ignored.
REQ-038 Reset asserted during MUL cycle 3 -> busy=0, rezult=0, zero=1 immediately; the next ADD 2+3 gives rezult=5.
REQ-039 Without macro, MUL a=2 b=2 after ADD result 5 -> err=1, rezult=5, done 2 cycles after enable.
REQ-040 SHL a=3 b=5 -> rezult=0; CMP a=2 b=9 -> rezult=1.
